dds_wave_gen: RTL and testbench

//  DDS core downstream of the key-driven wave selector. Consumes the one-hot wave_select code,

---
 rtl/dds_wave_gen_pkg.sv | 12 +
 rtl/dds_wave_gen_if.sv | 10 +
 rtl/dds_wave_gen_sin_rom.sv | 44 ++++
 rtl/dds_wave_gen.sv | 81 ++++++++
 tb/tb_dds_wave_gen.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/dds_wave_gen_pkg.sv
// Shared wave-select codes for the DDS core and the key-driven selector feeding it.
package dds_wave_gen_pkg;
  localparam logic [3:0] IDLE_WAVE = 4'b0000;
  localparam logic [3:0] SIN_WAVE  = 4'b0001;
  localparam logic [3:0] SQU_WAVE  = 4'b0010;
  localparam logic [3:0] TRI_WAVE  = 4'b0100;
  localparam logic [3:0] SAW_WAVE  = 4'b1000;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/dds_wave_gen_if.sv
// Wave-select / tuning inputs and parallel DAC outputs of the DDS core.
interface dds_wave_gen_if #(parameter int PHASE_W = 32, parameter int DATA_W = 8);
  logic [3:0]         wave_select;
  logic [PHASE_W-1:0] freq_word;
  logic [DATA_W-1:0]  dac_data;
  logic               dac_valid;

  modport master (output wave_select, freq_word, input dac_data, dac_valid);
  modport slave  (input wave_select, freq_word, output dac_data, dac_valid);
endinterface

// File: rtl/dds_wave_gen_sin_rom.sv
// Sine ROM, synchronous read; contents built at elaboration as round(max/2*(1+sin)).
module sin_rom #(parameter int ADDR_W = 10, parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);
  localparam int     DEPTH = 1 << ADDR_W;
  localparam longint ONE   = 64'sd1 << 30;
  localparam longint PI_Q  = 64'sd3373259426;

  // Quarter-wave folding plus a Q30 Taylor series keeps the table integer-exact at elaboration.
  function automatic logic [DATA_W-1:0] sin_val(input int i);
    longint n, q_idx, x, x2, term, s, num;
    n = longint'(1) << ADDR_W;
    if (i <= n / 4)          q_idx = i;
    else if (i <= n / 2)     q_idx = n / 2 - i;
    else if (i <= 3 * n / 4) q_idx = i - n / 2;
    else                     q_idx = n - i;
    x    = (q_idx * PI_Q) >>> (ADDR_W - 1);
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    if (i > n / 2) s = -s;
    num = ((longint'(1) << DATA_W) - 1) * (ONE + s) + ONE;
    return DATA_W'(num >>> 31);
  endfunction

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_W-1:0] V = sin_val(g);
    assign rom[g] = V;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= rom[addr];
  end
endmodule

// File: rtl/dds_wave_gen.sv
// DDS core: phase accumulator, sine ROM and shape logic, one registered DAC sample per clock.
module dds_wave_gen
  import dds_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  dds_wave_gen_if.slave  bus
);
  localparam int STAGES = 2;
  localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

  if (ADDR_W < DATA_W + 1) begin : g_chk
    $error("dds_wave_gen: ADDR_W must be at least DATA_W+1");
  end

  logic [3:0]         mode_r, mode_d;
  logic [PHASE_W-1:0] acc;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W:0]    addr_d;   // only the top DATA_W+1 phase bits shape square/tri/saw
  logic [DATA_W-1:0]  rom_q, dac_q;
  logic [STAGES:1]    vld_pipe;

  // Stage A: a new legal wave restarts at phase 0; non-one-hot codes are ignored.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mode_r <= IDLE_WAVE;
      acc    <= '0;
    end else if (bus.wave_select == IDLE_WAVE) begin
      mode_r <= IDLE_WAVE;
      acc    <= '0;
    end else if (is_onehot(bus.wave_select) && bus.wave_select != mode_r) begin
      mode_r <= bus.wave_select;
      acc    <= '0;
    end else if (mode_r != IDLE_WAVE) begin
      acc <= acc + bus.freq_word;
    end
  end

  assign addr = acc[PHASE_W-1 -: ADDR_W];

  sin_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .addr  (addr),
    .q     (rom_q)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      addr_d   <= '0;
      mode_d   <= IDLE_WAVE;
      vld_pipe <= '0;
    end else begin
      addr_d   <= addr[ADDR_W-1 -: DATA_W+1];
      mode_d   <= mode_r;
      vld_pipe <= {vld_pipe[STAGES-1:1], mode_r != IDLE_WAVE};
    end
  end

  // Stage C
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dac_q <= MID;
    end else begin
      case (mode_d)
        SIN_WAVE: dac_q <= rom_q;
        SQU_WAVE: dac_q <= {DATA_W{~addr_d[DATA_W]}};
        TRI_WAVE: dac_q <= addr_d[DATA_W] ? ~addr_d[DATA_W-1:0] : addr_d[DATA_W-1:0];
        SAW_WAVE: dac_q <= addr_d[DATA_W:1];
        default:  dac_q <= MID;
      endcase
    end
  end

  assign bus.dac_data  = dac_q;
  assign bus.dac_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: directed vector table, corner sequences, randomized run vs. a sample-level model.
module tb_dds_wave_gen;
  localparam int PW = 32, AW = 10, DW = 8;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  dds_wave_gen_if #(.PHASE_W(PW), .DATA_W(DW)) bus();
  dds_wave_gen #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int sin_tab [1024];

  // Model: what the core shows two edges after a (mode, phase) pair is held.
  bit [3:0]  m_mode;
  bit [31:0] m_acc;
  int        pend_d, exp_d;
  bit        pend_v, exp_v;

  typedef struct {
    logic [3:0]  ws;
    logic [31:0] fw;
    int          edges;
    int          exp_d;
    bit          exp_v;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int shape(input bit [3:0] m, input bit [31:0] a);
    int p;
    p = int'(a / 32'h0040_0000);
    case (m)
      4'b0001: return sin_tab[p];
      4'b0010: return (p < 512) ? 255 : 0;
      4'b0100: return (p < 512) ? p / 2 : 255 - (p - 512) / 2;
      4'b1000: return p / 4;
      default: return 128;
    endcase
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      exp_d = 128; exp_v = 0;
      pend_d = 128; pend_v = 0;
      m_mode = 0; m_acc = 0;
    end else begin
      exp_d = pend_d; exp_v = pend_v;
      pend_d = shape(m_mode, m_acc);
      pend_v = (m_mode != 0);
      if (bus.wave_select == 4'b0000) begin
        m_mode = 0; m_acc = 0;
      end else if ($countones(bus.wave_select) == 1 && bus.wave_select != m_mode) begin
        m_mode = bus.wave_select; m_acc = 0;
      end else if (m_mode != 0) begin
        m_acc = m_acc + bus.freq_word;
      end
    end
    #1;
    chk("model_data", int'(bus.dac_data), exp_d);
    chk("model_valid", int'(bus.dac_valid), int'(exp_v));
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    chk("rst_data", int'(bus.dac_data), 8'h80);
    chk("rst_valid", int'(bus.dac_valid), 0);
    sys_rst_n = 1'b1;
  endtask

  logic [3:0] ws_pool [13] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'h9, 4'hF,
                               4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    for (int i = 0; i < 1024; i++)
      sin_tab[i] = int'($floor(127.5 * (1.0 + $sin(2.0 * 3.14159265358979323846 * i / 1024.0)) + 0.5));
    m_mode = 0; m_acc = 0; pend_d = 128; pend_v = 0;
    bus.wave_select = 4'b0000;
    bus.freq_word   = 32'h0040_0000;
    sys_rst_n       = 1'b0;

    vt.push_back('{4'b0001, 32'h0040_0000, 3,        8'h80, 1'b1});
    vt.push_back('{4'b0001, 32'h0040_0000, 3 + 256,  8'hFF, 1'b1});
    vt.push_back('{4'b0001, 32'h0040_0000, 3 + 768,  8'h00, 1'b1});
    vt.push_back('{4'b0010, 32'h0040_0000, 3,        8'hFF, 1'b1});
    vt.push_back('{4'b0010, 32'h0040_0000, 3 + 511,  8'hFF, 1'b1});
    vt.push_back('{4'b0010, 32'h0040_0000, 3 + 512,  8'h00, 1'b1});
    vt.push_back('{4'b0010, 32'h0040_0000, 3 + 1024, 8'hFF, 1'b1});
    vt.push_back('{4'b0100, 32'h0040_0000, 4,        8'h00, 1'b1});
    vt.push_back('{4'b0100, 32'h0040_0000, 5,        8'h01, 1'b1});
    vt.push_back('{4'b0100, 32'h0040_0000, 3 + 511,  8'hFF, 1'b1});
    vt.push_back('{4'b0100, 32'h0040_0000, 3 + 512,  8'hFF, 1'b1});
    vt.push_back('{4'b0100, 32'h0040_0000, 3 + 1023, 8'h00, 1'b1});
    vt.push_back('{4'b1000, 32'h0040_0000, 6,        8'h00, 1'b1});
    vt.push_back('{4'b1000, 32'h0040_0000, 7,        8'h01, 1'b1});
    vt.push_back('{4'b1000, 32'h0040_0000, 3 + 1023, 8'hFF, 1'b1});
    vt.push_back('{4'b0000, 32'h0040_0000, 3,        8'h80, 1'b0});
    vt.push_back('{4'b0100, 32'h0000_0000, 10,       8'h00, 1'b1});
    vt.push_back('{4'b0011, 32'h0040_0000, 10,       8'h80, 1'b0});

    foreach (vt[k]) begin
      do_reset();
      bus.wave_select = vt[k].ws;
      bus.freq_word   = vt[k].fw;
      repeat (vt[k].edges) tick();
      chk($sformatf("vec%0d_data", k), int'(bus.dac_data), vt[k].exp_d);
      chk($sformatf("vec%0d_valid", k), int'(bus.dac_valid), int'(vt[k].exp_v));
    end

    // Saw -> triangle mid-period restarts at phase 0 three edges later.
    do_reset();
    bus.wave_select = 4'b1000; bus.freq_word = 32'h0040_0000;
    repeat (100) tick();
    bus.wave_select = 4'b0100;
    repeat (2) tick();
    chk("saw2tri_e2", int'(bus.dac_data), 8'd24);
    tick();
    chk("saw2tri_e3", int'(bus.dac_data), 8'h00);

    // Illegal code is ignored, then idle after three edges.
    do_reset();
    bus.wave_select = 4'b0010;
    repeat (500) tick();
    bus.wave_select = 4'b0011;
    repeat (20) tick();
    chk("ill_hold", int'(bus.dac_data), 8'h00);
    bus.wave_select = 4'b0000;
    repeat (2) tick();
    chk("idle_e2_valid", int'(bus.dac_valid), 1);
    tick();
    chk("idle_e3_data", int'(bus.dac_data), 8'h80);
    chk("idle_e3_valid", int'(bus.dac_valid), 0);

    // Nyquist square, then a one-cycle reset mid-run.
    do_reset();
    bus.wave_select = 4'b0010; bus.freq_word = 32'h8000_0000;
    repeat (3) tick();
    chk("nyq_0", int'(bus.dac_data), 8'hFF);
    tick();
    chk("nyq_1", int'(bus.dac_data), 8'h00);
    tick();
    chk("nyq_2", int'(bus.dac_data), 8'hFF);
    do_reset();
    repeat (2) tick();
    chk("rel_e2_valid", int'(bus.dac_valid), 0);
    tick();
    chk("rel_e3_data", int'(bus.dac_data), 8'hFF);
    chk("rel_e3_valid", int'(bus.dac_valid), 1);

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) bus.wave_select = ws_pool[$urandom_range(0, 12)];
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.freq_word = $urandom;
          1: bus.freq_word = 32'h0040_0000 * $urandom_range(1, 8);
          2: bus.freq_word = 32'h0;
          default: bus.freq_word = 32'h8000_0000;
        endcase
      end
      sys_rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
